pwm_channel_bank: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the station system's fixed two-channel electromagnet/servo driver. A single shared period counter drives `NCH` compare channels. Each channel selects between two per-channel duty presets using one control bit. Duty changes are applied only at period boundaries, so no output ever sees a glitch or a runt pulse. Each channel can optionally slew toward its new duty, which keeps the servo from snapping between positions. The block sits between the station control FSM and the electromagnet switch and servo pins.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 44 ++++
 rtl/pwm_channel_bank.sv | 55 +++++
 tb/tb_pwm_channel_bank.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, station presets and preset slicing for the PWM bank
package pwm_pkg;
  localparam int W_DEF       = 10;
  localparam int PERIOD_DEF  = 976;
  localparam int PRESET_BITS = 1024;

  localparam int EM_OFF     = 0;
  localparam int EM_ON      = 100;
  localparam int SERVO_UP   = 50;
  localparam int SERVO_DOWN = 100;

  // Channel ch of a packed preset vector whose channels are w bits wide.
  function automatic logic [31:0] preset_at(input logic [PRESET_BITS-1:0] vec,
                                            input int ch, input int w);
    logic [PRESET_BITS-1:0] s;
    s = vec >> (ch * w);
    return s[31:0] & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty register, boundary-only ramp, compare and output flop
module pwm_channel #(
  parameter int           W    = 10,
  parameter logic [W-1:0] LO   = '0,
  parameter logic [W-1:0] HI   = '0,
  parameter logic [W-1:0] STEP = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic         wrap,
  input  logic         sel,
  input  logic [W-1:0] cnt,
  output logic         pwm,
  output logic         settled
);
  logic [W-1:0] duty;
  logic [W-1:0] tgt;
  logic         up;
  logic [W:0]   mag;
  logic [W:0]   step;
  logic [W:0]   nxt;

  // One extra bit keeps the distance to the target from wrapping.
  always_comb begin
    tgt  = sel ? HI : LO;
    up   = tgt > duty;
    mag  = up ? ({1'b0, tgt} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, tgt});
    step = (STEP == '0 || mag < {1'b0, STEP}) ? mag : {1'b0, STEP};
    nxt  = up ? ({1'b0, duty} + step) : ({1'b0, duty} - step);
  end

  assign settled = (duty == tgt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      duty <= LO;
      pwm  <= 1'b0;
    end else begin
      if (wrap) duty <= W'(nxt);
      pwm <= en && (cnt < duty);
    end
  end
endmodule

// File: rtl/pwm_channel_bank.sv
// rtl/pwm_channel_bank.sv - NCH PWM channels sharing one period counter
module pwm_channel_bank
  import pwm_pkg::*;
#(
  parameter int               NCH       = 2,
  parameter int               W         = W_DEF,
  parameter int               PERIOD    = PERIOD_DEF,
  parameter logic [NCH*W-1:0] DUTY_LO   = {W'(SERVO_UP), W'(EM_OFF)},
  parameter logic [NCH*W-1:0] DUTY_HI   = {W'(SERVO_DOWN), W'(EM_ON)},
  parameter logic [NCH*W-1:0] RAMP_STEP = {W'(10), W'(0)}
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           en,
  input  logic [NCH-1:0] sel,
  output logic [NCH-1:0] pwm,
  output logic           period_start,
  output logic [NCH-1:0] settled
);
  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = en && (cnt == W'(PERIOD - 1));

  // The strobe is registered alongside pwm, so it marks the output cycle of cnt=0,
  // both after a wrap and on the first enabled cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(
      .W   (W),
      .LO  (W'(preset_at(PRESET_BITS'(DUTY_LO), i, W))),
      .HI  (W'(preset_at(PRESET_BITS'(DUTY_HI), i, W))),
      .STEP(W'(preset_at(PRESET_BITS'(RAMP_STEP), i, W)))
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .en     (en),
      .wrap   (wrap),
      .sel    (sel[i]),
      .cnt    (cnt),
      .pwm    (pwm[i]),
      .settled(settled[i])
    );
  end
endmodule

// File: tb/tb_pwm_channel_bank.sv
// tb/tb_pwm_channel_bank.sv - self-checking bench for pwm_channel_bank
`define CHECK(tag, obs, exp) begin checks++; assert (32'(obs) === 32'(exp)) else begin failures++; $error("FAIL %s observed=%0d expected=%0d", tag, 32'(obs), 32'(exp)); end end

module tb_pwm_channel_bank;
  localparam int P = 976;

  logic       CLK = 1'b0;
  logic       RST, en;
  logic [1:0] sel, pwm, settled;
  logic       period_start;

  logic       rst_e, en_e, ps_e;
  logic [2:0] sel_e, pwm_e, settled_e;

  int checks = 0;
  int failures = 0;

  int lo_v[2] = '{0, 50};
  int hi_v[2] = '{100, 100};
  int rs_v[2] = '{0, 10};
  int m_duty[2];

  always #5 CLK = ~CLK;

  pwm_channel_bank dut (
    .CLK(CLK), .RST(RST), .en(en), .sel(sel),
    .pwm(pwm), .period_start(period_start), .settled(settled)
  );

  pwm_channel_bank #(
    .NCH(3), .W(4), .PERIOD(8),
    .DUTY_LO(12'h000), .DUTY_HI({4'd0, 4'd9, 4'd8}), .RAMP_STEP(12'h000)
  ) dut_e (
    .CLK(CLK), .RST(rst_e), .en(en_e), .sel(sel_e),
    .pwm(pwm_e), .period_start(ps_e), .settled(settled_e)
  );

  function automatic int tgt_of(int ch, logic s);
    return s ? hi_v[ch] : lo_v[ch];
  endfunction

  function automatic int ramp(int d, int t, int r);
    if (r == 0) return t;
    if (t > d) return d + (((t - d) < r) ? (t - d) : r);
    return d - (((d - t) < r) ? (d - t) : r);
  endfunction

  // Observes one full period starting at its cycle-0 output sample; optional sel edits mid-period.
  task automatic measure_period(input int chg_at, input logic [1:0] chg_val,
                                input int rev_at, input logic [1:0] rev_val);
    int high[2];
    int shape_err[2];
    int exp_high[2];
    int ps_err;
    logic [1:0] wrap_sel;
    ps_err = 0;
    wrap_sel = sel;
    for (int ch = 0; ch < 2; ch++) begin
      high[ch] = 0;
      shape_err[ch] = 0;
      exp_high[ch] = (m_duty[ch] < P) ? m_duty[ch] : P;
    end
    for (int j = 0; j < P; j++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (pwm[ch] === 1'b1) high[ch]++;
        if (pwm[ch] !== 1'(j < exp_high[ch])) shape_err[ch]++;
      end
      if (period_start !== 1'(j == 0)) ps_err++;
      if (j == P - 3)
        for (int ch = 0; ch < 2; ch++)
          `CHECK($sformatf("settled%0d", ch), settled[ch], (m_duty[ch] == tgt_of(ch, sel[ch])))
      if (j == chg_at) sel = chg_val;
      if (j == rev_at) sel = rev_val;
      if (j == P - 2) wrap_sel = sel;
      @(negedge CLK);
    end
    for (int ch = 0; ch < 2; ch++) begin
      `CHECK($sformatf("high_time_ch%0d", ch), high[ch], exp_high[ch])
      `CHECK($sformatf("pulse_shape_ch%0d", ch), shape_err[ch], 0)
      m_duty[ch] = ramp(m_duty[ch], tgt_of(ch, wrap_sel[ch]), rs_v[ch]);
    end
    `CHECK("period_start_pattern", ps_err, 0)
  endtask

  initial begin
    int lo_err, hi_err, ps_cnt, chg, rev;
    logic [1:0] v1, v2;
    RST = 1'b1; en = 1'b0; sel = 2'b00;
    rst_e = 1'b1; en_e = 1'b0; sel_e = 3'b000;
    m_duty[0] = lo_v[0];
    m_duty[1] = lo_v[1];
    repeat (3) @(negedge CLK);
    `CHECK("reset_pwm", pwm, 2'b00)
    `CHECK("reset_period_start", period_start, 1'b0)
    `CHECK("reset_settled", settled, 2'b11)

    RST = 1'b0;
    @(negedge CLK);
    `CHECK("idle_period_start", period_start, 1'b0)
    en = 1'b1;
    @(negedge CLK);

    measure_period(-1, 2'b00, -1, 2'b00);
    measure_period(299, 2'b01, -1, 2'b00);
    measure_period(10, 2'b11, -1, 2'b00);
    repeat (5) measure_period(-1, 2'b00, -1, 2'b00);
    `CHECK("ramp_final_duty_model", m_duty[1], 100)
    measure_period(400, 2'b10, 420, 2'b11);

    for (int j = 0; j < 29; j++) @(negedge CLK);
    `CHECK("pre_disable_ch1_high", pwm[1], 1'b1)
    en = 1'b0;
    @(negedge CLK);
    `CHECK("disable_pwm_clear", pwm, 2'b00)
    repeat (5) @(negedge CLK);
    `CHECK("disabled_pwm_low", pwm, 2'b00)
    `CHECK("disabled_no_strobe", period_start, 1'b0)
    en = 1'b1;
    @(negedge CLK);
    measure_period(-1, 2'b00, -1, 2'b00);

    for (int k = 0; k < 6; k++) begin
      chg = int'($urandom_range(0, P - 3));
      v1 = 2'($urandom_range(0, 3));
      v2 = 2'($urandom_range(0, 3));
      rev = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, P - 3)) : -1;
      if (rev <= chg) rev = -1;
      measure_period(chg, v1, rev, v2);
    end

    sel = 2'b00;
    measure_period(-1, 2'b00, -1, 2'b00);
    for (int j = 0; j < 10; j++) @(negedge CLK);
    RST = 1'b1;
    sel = 2'b11;
    @(negedge CLK);
    `CHECK("reset_mid_pulse_pwm", pwm, 2'b00)
    `CHECK("reset_mid_pulse_strobe", period_start, 1'b0)
    `CHECK("reset_duty_to_lo", settled, 2'b00)
    @(negedge CLK);
    `CHECK("reset_wins_over_en", pwm, 2'b00)
    m_duty[0] = lo_v[0];
    m_duty[1] = lo_v[1];
    RST = 1'b0;
    @(negedge CLK);
    measure_period(-1, 2'b00, -1, 2'b00);
    measure_period(-1, 2'b00, -1, 2'b00);

    rst_e = 1'b0;
    sel_e = 3'b111;
    en_e = 1'b1;
    lo_err = 0; hi_err = 0; ps_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (ps_e === 1'b1) ps_cnt++;
      if (n <= 8 && pwm_e !== 3'b000) lo_err++;
      if (n > 8 && pwm_e !== 3'b011) hi_err++;
    end
    `CHECK("edge_first_period_low", lo_err, 0)
    `CHECK("edge_full_duty_high", hi_err, 0)
    `CHECK("edge_strobe_count", ps_cnt, 5)
    `CHECK("edge_settled", settled_e, 3'b111)
    rst_e = 1'b1;
    @(negedge CLK);
    `CHECK("edge_reset_pwm", pwm_e, 3'b000)
    `CHECK("edge_reset_duty_lo", settled_e, 3'b100)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
